// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and helpers for the SRAM port arbiter (package sram_arb_pkg).
package sram_arb_pkg;

   localparam int NCH_DEF = 2;
   localparam int DW_DEF  = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // A single channel still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction

   localparam int              IDX_W    = idx_width(NCH_DEF);
   localparam int              BE_W     = be_width(DW_DEF);
   localparam logic [BE_W-1:0] READ_WEN = '0;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request-side and memory-side bundle of the SRAM port arbiter.
interface sram_port_arbiter_if #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
);
   logic [NCH-1:0]          req_en;
   logic [NCH*(DW/8)-1:0]   req_wen;
   logic [NCH*AW-1:0]       req_addr;
   logic [NCH*DW-1:0]       req_wdata;
   logic [NCH-1:0]          stall;
   logic [NCH-1:0]          rsp_valid;
   logic [NCH*DW-1:0]       rsp_rdata;
   logic                    mem_en;
   logic [DW/8-1:0]         mem_wen;
   logic [AW-1:0]           mem_addr;
   logic [DW-1:0]           mem_wdata;
   logic [DW-1:0]           mem_rdata;

   modport slave (
      input  req_en, req_wen, req_addr, req_wdata, mem_rdata,
      output stall, rsp_valid, rsp_rdata, mem_en, mem_wen, mem_addr, mem_wdata
   );

   modport master (
      output req_en, req_wen, req_addr, req_wdata, mem_rdata,
      input  stall, rsp_valid, rsp_rdata, mem_en, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_port_arbiter_rr_picker.sv
// One-hot round-robin picker: search starts at (last + 1) mod NCH.
module rr_picker #(
   parameter int NCH = 2,
   parameter int IW  = 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last,
   output logic [NCH-1:0] grant
);

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = int'(last) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-channel arbiter onto one single-port SRAM with one-cycle read return.
// SRAM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic            clk,
   input  logic            rst,
   sram_port_arbiter_if.slave bus
);

   localparam int             BW     = be_width(DW);
   localparam int             IW     = idx_width(NCH);
   localparam logic [BW-1:0]  RD_WEN = BW'(READ_WEN);

   logic [NCH-1:0]    req_v;
   logic [NCH-1:0]    grant;
   logic [IW-1:0]     last_ptr;
   logic [IW-1:0]     gidx;
   logic [BW-1:0]     g_wen;
   logic [AW-1:0]     g_addr;
   logic [DW-1:0]     g_wdata;
   logic              pend_vld_q, pend_vld_d;
   logic [IW-1:0]     pend_ch_q, pend_ch_d;
   logic [NCH*DW-1:0] hold_q;
   logic [NCH-1:0]    rsp_valid;
   logic [NCH*DW-1:0] rsp_rdata;

   // Nothing is granted while reset is held.
   assign req_v = bus.req_en & {NCH{~rst}};

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign last_ptr = IW'(NCH - 1);
`else
   logic [IW-1:0] last_q, last_d;

   assign last_d   = (|grant) ? gidx : last_q;
   assign last_ptr = last_q;

   always_ff @(posedge clk) begin
      if (rst) last_q <= IW'(NCH - 1);
      else     last_q <= last_d;
   end
`endif

   rr_picker #(.NCH(NCH), .IW(IW)) u_picker (
      .req   (req_v),
      .last  (last_ptr),
      .grant (grant)
   );

   always_comb begin
      gidx    = '0;
      g_wen   = '0;
      g_addr  = '0;
      g_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            gidx    = IW'(i);
            g_wen   = bus.req_wen[i*BW +: BW];
            g_addr  = bus.req_addr[i*AW +: AW];
            g_wdata = bus.req_wdata[i*DW +: DW];
         end
      end
   end

   assign bus.mem_en    = |grant;
   assign bus.mem_wen   = g_wen;
   assign bus.mem_addr  = g_addr;
   assign bus.mem_wdata = g_wdata;
   assign bus.stall     = bus.req_en & ~grant;

   assign pend_vld_d = (|grant) && (g_wen == RD_WEN);
   assign pend_ch_d  = gidx;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         pend_ch_q  <= '0;
         hold_q     <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_ch_q  <= pend_ch_d;
         for (int i = 0; i < NCH; i++) begin
            if (pend_vld_q && (pend_ch_q == IW'(i))) hold_q[i*DW +: DW] <= bus.mem_rdata;
         end
      end
   end

   // The resolving channel sees mem_rdata directly; afterwards the held copy.
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!rst) begin
            rsp_valid[i] = pend_vld_q && (pend_ch_q == IW'(i));
            rsp_rdata[i*DW +: DW] = rsp_valid[i] ? bus.mem_rdata : hold_q[i*DW +: DW];
         end
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a 2-channel and a 4-channel instance.
module tb_sram_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run  = 0;
   int   n_fail = 0;
   int   exp_ch;
   int   prev_ch;

   always #5 clk = ~clk;

   sram_port_arbiter_if #(.NCH(2), .AW(32), .DW(32)) b2 ();
   sram_port_arbiter_if #(.NCH(4), .AW(32), .DW(32)) b4 ();

   sram_port_arbiter #(.NCH(2), .AW(32), .DW(32)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (b2)
   );

   sram_port_arbiter #(.NCH(4), .AW(32), .DW(32)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      b2.req_en = '0; b2.req_wen = '0; b2.req_addr = '0; b2.req_wdata = '0; b2.mem_rdata = '0;
      b4.req_en = '0; b4.req_wen = '0; b4.req_addr = '0; b4.req_wdata = '0; b4.mem_rdata = '0;

      // reset with both channels requesting
      rst = 1'b1;
      b2.req_en = 2'b11;
      mid();
      chk("rst_mem_en", b2.mem_en, 0);
      chk("rst_stall", b2.stall, 2'b11);
      chk("rst_rsp_valid", b2.rsp_valid, 0);
      chk("rst_rdata", b2.rsp_rdata, 0);
      tick();

      // single uncontended read on ch0
      rst = 1'b0;
      b2.req_en = 2'b01;
      b2.req_addr = {32'h0, 32'h100};
      mid();
      chk("rd_mem_en", b2.mem_en, 1);
      chk("rd_mem_addr", b2.mem_addr, 32'h100);
      chk("rd_mem_wen", b2.mem_wen, 0);
      chk("rd_stall", b2.stall, 2'b00);
      chk("rd_rsp_early", b2.rsp_valid, 2'b00);
      tick();
      b2.req_en = 2'b00;
      b2.mem_rdata = 32'hDEADBEEF;
      mid();
      chk("rd_rsp_valid", b2.rsp_valid, 2'b01);
      chk("rd_rdata", b2.rsp_rdata[31:0], 32'hDEADBEEF);
      tick();
      b2.mem_rdata = 32'h0;
      mid();
      chk("rd_rsp_once", b2.rsp_valid, 2'b00);
      chk("rd_rdata_hold", b2.rsp_rdata[31:0], 32'hDEADBEEF);
      chk("rd_idle_en", b2.mem_en, 0);
      tick();

      // read granted, reset asserted the next cycle
      b2.req_en = 2'b01;
      b2.req_addr = {32'h0, 32'h104};
      mid();
      chk("rr_pre_en", b2.mem_en, 1);
      tick();
      rst = 1'b1;
      b2.mem_rdata = 32'hCAFEF00D;
      mid();
      chk("inrst_rsp_valid", b2.rsp_valid, 0);
      chk("inrst_rdata", b2.rsp_rdata[31:0], 0);
      chk("inrst_mem_en", b2.mem_en, 0);
      chk("inrst_stall", b2.stall, 2'b01);
      tick();
      rst = 1'b0;
      b2.req_en = 2'b00;
      mid();
      chk("postrst_no_rsp", b2.rsp_valid, 0);
      chk("postrst_rdata", b2.rsp_rdata, 0);
      tick();

      // two channels reading continuously: 0,1,0,1
      b2.req_en = 2'b11;
      b2.req_addr = {32'h20, 32'h10};
      for (int k = 0; k < 4; k++) begin
         b2.mem_rdata = 32'hA0 + k;
         exp_ch  = k % 2;
         prev_ch = 1 - exp_ch;
         mid();
         chk("alt_addr", b2.mem_addr, (exp_ch == 1) ? 32'h20 : 32'h10);
         chk("alt_stall", b2.stall, (exp_ch == 1) ? 2'b01 : 2'b10);
         if (k == 0) begin
            chk("alt_rsp_first", b2.rsp_valid, 2'b00);
         end else begin
            chk("alt_rsp", b2.rsp_valid, (prev_ch == 1) ? 2'b10 : 2'b01);
            chk("alt_rdata", b2.rsp_rdata[prev_ch*32 +: 32], 32'hA0 + k);
         end
         tick();
      end
      b2.req_en = 2'b00;
      b2.mem_rdata = 32'hA4;
      mid();
      chk("alt_rsp_last", b2.rsp_valid, 2'b10);
      chk("alt_rdata_last", b2.rsp_rdata[63:32], 32'hA4);
      tick();
      b2.mem_rdata = 32'h0;
      mid();
      chk("alt_hold0", b2.rsp_rdata[31:0], 32'hA3);
      chk("alt_hold1", b2.rsp_rdata[63:32], 32'hA4);
      chk("alt_rsp_none", b2.rsp_valid, 2'b00);
      tick();

      // ch1 partial write, no contention
      b2.req_en = 2'b10;
      b2.req_wen = 8'b0011_0000;
      b2.req_addr = {32'h200, 32'h10};
      b2.req_wdata = {32'h12345678, 32'h0};
      mid();
      chk("wr_mem_en", b2.mem_en, 1);
      chk("wr_mem_wen", b2.mem_wen, 4'b0011);
      chk("wr_mem_wdata", b2.mem_wdata, 32'h12345678);
      chk("wr_mem_addr", b2.mem_addr, 32'h200);
      chk("wr_stall", b2.stall, 2'b00);
      tick();
      b2.req_en = 2'b00;
      mid();
      chk("wr_no_rsp", b2.rsp_valid, 2'b00);
      tick();

      // ch0 write moves last to 0, then idle with fields still driven
      b2.req_en = 2'b01;
      b2.req_wen = 8'b0011_1111;
      b2.req_addr = {32'h200, 32'h300};
      b2.req_wdata = {32'h12345678, 32'h55AA55AA};
      mid();
      chk("wr0_mem_wen", b2.mem_wen, 4'hF);
      tick();
      b2.req_en = 2'b00;
      mid();
      chk("idle_mem_en", b2.mem_en, 0);
      chk("idle_mem_addr", b2.mem_addr, 0);
      chk("idle_mem_wen", b2.mem_wen, 0);
      chk("idle_mem_wdata", b2.mem_wdata, 0);
      chk("idle_no_rsp", b2.rsp_valid, 0);
      tick();
      tick();
      b2.req_en = 2'b11;
      mid();
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk("idle_then_contend_stall", b2.stall, 2'b10);
      chk("idle_then_contend_addr", b2.mem_addr, 32'h300);
`else
      chk("idle_then_contend_stall", b2.stall, 2'b01);
      chk("idle_then_contend_addr", b2.mem_addr, 32'h200);
`endif
      tick();
      b2.req_en = 2'b00;

      // four channels all requesting from reset
      rst = 1'b1;
      mid();
      chk("rst4_mem_en", b4.mem_en, 0);
      chk("rst4_rsp_valid", b4.rsp_valid, 0);
      tick();
      rst = 1'b0;
      b4.req_en = 4'hF;
      b4.req_addr = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
      for (int c = 0; c < 5; c++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         exp_ch = 0;
`else
         exp_ch = c % 4;
`endif
         mid();
         chk("nch4_addr", b4.mem_addr, 32'h1000 + exp_ch);
         chk("nch4_stall", b4.stall, 4'hF & ~(4'b0001 << exp_ch));
         tick();
      end
      b4.req_en = 4'h0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Parametrised N-channel arbiter that merges several sram-like request ports from the core (instruction fetch, data load/store, and any later masters) onto one synchronous single-port SRAM interface. It grants one channel per cycle with round-robin fairness and stalls the losing channels. It returns read data one cycle after the grant and holds each channel's last read data. It sits between `mycpu_core` and a shared memory, and generalises the fixed separate inst/data SRAM ports of the current top.

## Interface
Parameters:
- `NCH`, 2, number of request channels (1..8)
- `AW`, 32, address width
- `DW`, 32, data width; byte-write-enable width is DW/8

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_en`  in  NCH  per-channel request valid
- `req_wen`  in  NCH*DW/8  per-channel byte write enables; all-zero = read
- `req_addr`  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
- `req_wdata`  in  NCH*DW  per-channel write data
- `stall`  out  NCH  channel must hold its request stable this cycle
- `rsp_valid`  out  NCH  one-cycle pulse: read data for channel i is valid
- `rsp_rdata`  out  NCH*DW  per-channel read data, held until the next read completes on that channel
- `mem_en`  out  1  SRAM enable
- `mem_wen`  out  DW/8  SRAM byte write enables
- `mem_addr`  out  AW  SRAM address
- `mem_wdata`  out  DW  SRAM write data
- `mem_rdata`  in  DW  SRAM read data, valid the cycle after `mem_en`

## Operation
- Grant: combinational one-hot `grant` over the channels with `req_en` high. The search starts at channel `(last + 1) mod NCH`. `last` is a registered pointer.
- `last` updates to the granted index on any cycle with a grant. It is unchanged on cycles with no grant.
- Memory port is driven from the granted channel: `mem_en` = |grant; `mem_wen`/`mem_addr`/`mem_wdata` are the granted channel's fields. When there is no grant, all memory outputs are 0.
- `stall[i]` = `req_en[i] & ~grant[i]`. A stalled channel holds all its request fields; the arbiter does not latch requests.
- Read tracking: a granted read (`wen` == 0) registers `pend_ch` = index and `pend_vld` = 1. On the next cycle, `rsp_valid[pend_ch]` = 1 and `rsp_rdata[pend_ch]` <= `mem_rdata`, registered and then held.
- Writes produce no `rsp_valid`.
- Back-to-back grants to different channels pipeline freely. Each pending read resolves exactly one cycle later, independent of the current grant.
- `NCH` = 1: pointer logic degenerates; channel 0 is granted whenever it requests, and `stall` is constant 0.

## Timing
- Reset values: `last` = NCH-1, so channel 0 has first priority. `pend_vld` = 0. All `rsp_valid` = 0. All `rsp_rdata` = 0.
- While `rst` is high: grant is forced to 0, so `mem_en` = 0 and `stall` = `req_en`.
- A read issued in the same cycle `rst` rises is discarded: no `rsp_valid` after reset.
- Latency: request to grant is 0 cycles when uncontended. Read grant to `rsp_valid` is exactly 1 cycle.
- Worst-case wait for a continuously requesting channel is NCH-1 cycles.
- A channel granted in cycle t with its read response in t+1 may be granted again in t+1.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. The `last` register is not built, and starvation of high indices is allowed.
- Undefined (default): round-robin as described above.

## Structure
- Shared package `sram_arb_pkg`:
  - `clog2`-derived index width constant
  - byte-enable width constant (DW/8)
  - `READ_WEN` all-zero constant
- One sub-module, `rr_picker`: parametrised round-robin one-hot picker with inputs `req`, `last` and output `grant`. It is also used by the fixed-priority build, with `last` tied to NCH-1.

## Test plan
- Reset, then channel 0 reads 0x100 with `mem_rdata`=0xDEADBEEF. Response: `mem_en`=1 and `stall`=00 in cycle 0; `rsp_valid`=01 and ch0 `rsp_rdata`=0xDEADBEEF in cycle 1, held afterwards.
- Channels 0 and 1 both read continuously for 4 cycles (NCH=2). Response: grants alternate 0,1,0,1; `stall` alternates 10,01; each `rsp_valid` lags its grant by 1 cycle.
- Channel 1 writes `wen`=4'b0011, data 0x12345678, to 0x200 with no contention. Response: `mem_wen`=0011, `mem_wdata`=0x12345678, `stall`=00, no `rsp_valid`.
- NCH=4, all channels request, starting after reset. Response: grant order is 0,1,2,3,0. With `SRAM_ARB_FIXED_PRIO_EN` defined, the order is 0,0,0,0.
- Channel 0 read granted, then `rst` asserted in the next cycle. Response: `rsp_valid`=0, `rsp_rdata`=0, `mem_en`=0 during reset.
- Idle (`req_en`=0). Response: all `mem_*`=0; `last` unchanged, verified by a subsequent two-channel contention granting (last+1) first.
